// File: rtl/jogo_memoria_param_if.sv
// Signal bundle between the board top level and the memory-game engine.
interface jogo_memoria_param_if #(
  parameter int unsigned NBOTOES      = 4,
  parameter int unsigned PROFUNDIDADE = 16
);
  localparam int unsigned RW = $clog2(PROFUNDIDADE + 1);

  logic               tick;
  logic               pausa;
  logic               iniciar;
  logic               modo;
  logic [NBOTOES-1:0] botoes;
  logic [NBOTOES-1:0] leds;
  logic               pode_jogar;
  logic               pronto;
  logic               ganhou;
  logic               perdeu;
  logic               timeout;
  logic [RW-1:0]      rodada;
  logic [NBOTOES-1:0] db_esperado;
  logic [3:0]         db_estado;

  modport master (
    output tick, pausa, iniciar, modo, botoes,
    input  leds, pode_jogar, pronto, ganhou, perdeu, timeout, rodada, db_esperado, db_estado
  );

  modport slave (
    input  tick, pausa, iniciar, modo, botoes,
    output leds, pode_jogar, pronto, ganhou, perdeu, timeout, rodada, db_esperado, db_estado
  );
endinterface

// File: rtl/jogo_memoria_param.sv
// Sequence-memory game engine: builds a pseudo-random sequence over NBOTOES
// channels, replays it on the LEDs and checks the player's presses against it.
module jogo_memoria_param #(
  parameter int unsigned NBOTOES      = 4,
  parameter int unsigned PROFUNDIDADE = 16,
  parameter int unsigned TEMPO_LED    = 1000,
  parameter int unsigned TIMEOUT      = 5000,
  parameter logic [15:0] SEMENTE      = 16'hACE1
) (
  input logic                clock,
  input logic                reset,
  jogo_memoria_param_if.slave bus
);

  localparam int unsigned W  = $clog2(NBOTOES);
  localparam int unsigned RW = $clog2(PROFUNDIDADE + 1);
  localparam int unsigned IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StPrepara    = 4'd1,
    StMostra     = 4'd2,
    StApaga      = 4'd3,
    StEspera     = 4'd4,
    StCompara    = 4'd5,
    StProxRodada = 4'd6,
    StGanhou     = 4'd7,
    StPerdeu     = 4'd8
  } estado_e;

  estado_e            estado_q;
  logic [W-1:0]       seq_q [PROFUNDIDADE];
  logic [4:0]         idx_q;
  logic [RW-1:0]      rodada_q;
  logic [15:0]        timer_q;
  logic [15:0]        lfsr_q;
  logic               modo_q;
  logic               timeout_q;
  logic [NBOTOES-1:0] jogada_q;
  logic [NBOTOES-1:0] botoes_ant_q;

  logic [W-1:0]       elemento;
  logic [NBOTOES-1:0] esperado_oh;
  logic [15:0]        lfsr_prox;
  logic               evento;
  logic               fim_led;
  logic               fim_espera;
  logic               fim_seq;

  assign elemento    = seq_q[idx_q[IW-1:0]];
  assign esperado_oh = NBOTOES'(1) << elemento;
  // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
  assign lfsr_prox   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  // Press = rising from an all-released bus; a held button never re-triggers.
  assign evento      = (bus.botoes != '0) && (botoes_ant_q == '0);
  assign fim_led     = bus.tick && (timer_q == 16'(TEMPO_LED - 1));
  assign fim_espera  = bus.tick && (timer_q == 16'(TIMEOUT - 1));
  // idx is the last element of the current round.
  assign fim_seq     = ({1'b0, idx_q} + 6'd1) == 6'(rodada_q);

  // Engine FSM and datapath; pause freezes everything except the press-history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q     <= StInicial;
      seq_q        <= '{default: '0};
      idx_q        <= '0;
      rodada_q     <= '0;
      timer_q      <= '0;
      lfsr_q       <= SEMENTE;
      modo_q       <= 1'b0;
      timeout_q    <= 1'b0;
      jogada_q     <= '0;
      botoes_ant_q <= '0;
    end else begin
      botoes_ant_q <= bus.botoes;
      if (!bus.pausa) begin
        case (estado_q)
          StInicial: begin
            lfsr_q <= lfsr_prox;
            if (bus.iniciar) begin
              modo_q   <= bus.modo;
              estado_q <= StPrepara;
            end
          end
          StPrepara: begin
            rodada_q <= RW'(1);
            seq_q[0] <= lfsr_q[W-1:0];
            idx_q    <= '0;
            timer_q  <= '0;
            estado_q <= StMostra;
          end
          StMostra: begin
            if (fim_led) begin
              timer_q  <= '0;
              estado_q <= StApaga;
            end else if (bus.tick) begin
              timer_q <= timer_q + 16'd1;
            end
          end
          StApaga: begin
            if (fim_led) begin
              timer_q <= '0;
              if (fim_seq) begin
                idx_q    <= '0;
                estado_q <= StEspera;
              end else begin
                idx_q    <= idx_q + 5'd1;
                estado_q <= StMostra;
              end
            end else if (bus.tick) begin
              timer_q <= timer_q + 16'd1;
            end
          end
          StEspera: begin
            // A press in the same cycle as the timeout takes priority.
            if (evento) begin
              jogada_q <= bus.botoes;
              timer_q  <= '0;
              estado_q <= StCompara;
            end else if (fim_espera) begin
              timer_q   <= '0;
              timeout_q <= 1'b1;
              estado_q  <= StPerdeu;
            end else if (bus.tick) begin
              timer_q <= timer_q + 16'd1;
            end
          end
          StCompara: begin
            // Full-vector compare also rejects multi-bit presses.
            if (jogada_q != esperado_oh) begin
              estado_q <= StPerdeu;
            end else if (fim_seq) begin
              estado_q <= StProxRodada;
            end else begin
              idx_q    <= idx_q + 5'd1;
              estado_q <= StEspera;
            end
          end
          StProxRodada: begin
            if (rodada_q == RW'(PROFUNDIDADE)) begin
              estado_q <= StGanhou;
            end else begin
              seq_q[rodada_q[IW-1:0]] <= lfsr_q[W-1:0];
              rodada_q                <= rodada_q + RW'(1);
              // In modo 1 only the newest element (index = old rodada) is replayed.
              idx_q                   <= modo_q ? 5'(rodada_q) : 5'd0;
              timer_q                 <= '0;
              estado_q                <= StMostra;
            end
          end
          StGanhou, StPerdeu: begin
            lfsr_q <= lfsr_prox;
            if (bus.iniciar) begin
              modo_q    <= bus.modo;
              timeout_q <= 1'b0;
              estado_q  <= StPrepara;
            end
          end
          default: estado_q <= StInicial;
        endcase
      end
    end
  end

  // Moore outputs decoded from the state registers only.
  always_comb begin
    bus.leds        = (estado_q == StMostra) ? esperado_oh : '0;
    bus.pode_jogar  = (estado_q == StEspera);
    bus.pronto      = (estado_q == StGanhou) || (estado_q == StPerdeu);
    bus.ganhou      = (estado_q == StGanhou);
    bus.perdeu      = (estado_q == StPerdeu);
    bus.timeout     = (estado_q == StPerdeu) && timeout_q;
    bus.rodada      = rodada_q;
    bus.db_esperado = (estado_q == StEspera) ? esperado_oh : '0;
    bus.db_estado   = estado_q;
  end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Self-checking bench for jogo_memoria_param: randomized start delays and wrong
// presses, expected sequence/timing derived from the game rules.
module tb_jogo_memoria_param;

  localparam int unsigned NB   = 4;
  localparam int unsigned PROF = 2;
  localparam int unsigned TLED = 2;
  localparam int unsigned TOUT = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  jogo_memoria_param_if #(.NBOTOES(NB), .PROFUNDIDADE(PROF)) bus ();

  jogo_memoria_param #(
    .NBOTOES(NB),
    .PROFUNDIDADE(PROF),
    .TEMPO_LED(TLED),
    .TIMEOUT(TOUT),
    .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [NB-1:0] oh;
  logic [NB-1:0] wrong;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: seed stepped k times (x^16+x^14+x^13+x^11+1).
  function automatic logic [15:0] lfsr_after(input int k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    return s;
  endfunction

  task automatic apply_reset();
    reset       = 1'b1;
    bus.tick    = 1'b1;
    bus.pausa   = 1'b0;
    bus.iniciar = 1'b0;
    bus.modo    = 1'b0;
    bus.botoes  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Idles a random number of cycles in INICIAL, then pulses iniciar.
  // Every element of the game equals the LFSR value frozen at PREPARA.
  task automatic start_game(input logic modo, output logic [NB-1:0] elem_oh);
    int n;
    logic [15:0] s;
    n = $urandom_range(0, 40);
    s = lfsr_after(n + 1);
    elem_oh = 4'b0001 << s[1:0];
    bus.modo = modo;
    repeat (n) @(negedge clock);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.db_estado == code) break;
      @(negedge clock);
    end
    check("wait_state", {28'd0, bus.db_estado}, {28'd0, code});
  endtask

  // Called on the first lit sample; checks lit/dark durations, ends on ESPERA entry.
  task automatic watch_show(input int nelem, input logic [NB-1:0] elem_oh);
    for (int e = 0; e < nelem; e++) begin
      for (int c = 0; c < 2 * TLED; c++) begin
        check("leds", {28'd0, bus.leds}, (c < TLED) ? {28'd0, elem_oh} : 32'd0);
        @(negedge clock);
      end
    end
    check("espera_entry", {28'd0, bus.db_estado}, 32'd4);
    check("pode_jogar", {31'd0, bus.pode_jogar}, 32'd1);
    check("db_esperado", {28'd0, bus.db_esperado}, {28'd0, elem_oh});
  endtask

  // Drives a press for one cycle; returns on the sample after the decision edge-1 (COMPARA).
  task automatic press(input logic [NB-1:0] val);
    bus.botoes = val;
    @(negedge clock);
    bus.botoes = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int it = 0; it < 3; it++) begin
      // Reset values
      apply_reset();
      check("rst_estado", {28'd0, bus.db_estado}, 32'd0);
      check("rst_leds", {28'd0, bus.leds}, 32'd0);
      check("rst_rodada", {30'd0, bus.rodada}, 32'd0);
      check("rst_pronto", {31'd0, bus.pronto}, 32'd0);

      // Full win, modo 0
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      check("rodada1", {30'd0, bus.rodada}, 32'd1);
      watch_show(1, oh);
      press(oh);
      check("cmp1", {28'd0, bus.db_estado}, 32'd5);
      @(negedge clock);
      check("prox1", {28'd0, bus.db_estado}, 32'd6);
      @(negedge clock);
      check("mostra2", {28'd0, bus.db_estado}, 32'd2);
      check("rodada2", {30'd0, bus.rodada}, 32'd2);
      watch_show(2, oh);
      press(oh);
      check("cmp2a", {28'd0, bus.db_estado}, 32'd5);
      @(negedge clock);
      check("espera2b", {28'd0, bus.db_estado}, 32'd4);
      press(oh);
      @(negedge clock);
      check("prox2", {28'd0, bus.db_estado}, 32'd6);
      @(negedge clock);
      check("ganhou", {31'd0, bus.ganhou}, 32'd1);
      check("ganhou_pronto", {31'd0, bus.pronto}, 32'd1);
      check("ganhou_rodada", {30'd0, bus.rodada}, 32'd2);
      check("ganhou_perdeu", {31'd0, bus.perdeu}, 32'd0);
      repeat (3) @(negedge clock);
      check("ganhou_hold", {28'd0, bus.db_estado}, 32'd7);

      // Wrong press in round 1
      apply_reset();
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
      wrong = $urandom_range(0, 1) ? 4'b0011 : {oh[2:0], oh[3]};
      press(wrong);
      check("wrong_cmp", {28'd0, bus.db_estado}, 32'd5);
      @(negedge clock);
      check("wrong_estado", {28'd0, bus.db_estado}, 32'd8);
      check("wrong_perdeu", {31'd0, bus.perdeu}, 32'd1);
      check("wrong_timeout", {31'd0, bus.timeout}, 32'd0);
      check("wrong_pronto", {31'd0, bus.pronto}, 32'd1);

      // Timeout, with iniciar held (ignored) while waiting
      apply_reset();
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
      for (int i = 1; i < TOUT; i++) begin
        if (i == 1) bus.iniciar = 1'b1;
        @(negedge clock);
        check("to_wait", {28'd0, bus.db_estado}, 32'd4);
      end
      @(negedge clock);
      check("to_estado", {28'd0, bus.db_estado}, 32'd8);
      check("to_timeout", {31'd0, bus.timeout}, 32'd1);
      @(negedge clock);
      bus.iniciar = 1'b0;
      check("to_restart", {28'd0, bus.db_estado}, 32'd1);
      check("to_cleared", {31'd0, bus.timeout}, 32'd0);

      // Press on the last cycle before timeout wins
      apply_reset();
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
      repeat (TOUT - 1) @(negedge clock);
      press(oh);
      check("late_cmp", {28'd0, bus.db_estado}, 32'd5);
      check("late_timeout", {31'd0, bus.timeout}, 32'd0);
      @(negedge clock);
      check("late_prox", {28'd0, bus.db_estado}, 32'd6);

      // Pause in ESPERA, button pressed during pause and held through release
      apply_reset();
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
      bus.pausa = 1'b1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clock);
        if (i == 10) bus.botoes = oh;
        check("pausa_estado", {28'd0, bus.db_estado}, 32'd4);
      end
      bus.pausa = 1'b0;
      for (int i = 1; i < TOUT; i++) begin
        @(negedge clock);
        check("pos_pausa", {28'd0, bus.db_estado}, 32'd4);
      end
      @(negedge clock);
      check("pos_pausa_to", {28'd0, bus.db_estado}, 32'd8);
      check("pos_pausa_timeout", {31'd0, bus.timeout}, 32'd1);
      bus.botoes = '0;

      // modo 1: round 2 replays only the newest element
      apply_reset();
      start_game(1'b1, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
      press(oh);
      @(negedge clock);
      @(negedge clock);
      check("m1_mostra", {28'd0, bus.db_estado}, 32'd2);
      watch_show(1, oh);
      press(oh);
      @(negedge clock);
      check("m1_espera", {28'd0, bus.db_estado}, 32'd4);
      press(oh);
      @(negedge clock);
      @(negedge clock);
      check("m1_ganhou", {31'd0, bus.ganhou}, 32'd1);

      // Async reset mid-MOSTRA, then LFSR restarts from the seed
      apply_reset();
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      reset = 1'b1;
      #1;
      check("amid_estado", {28'd0, bus.db_estado}, 32'd0);
      check("amid_leds", {28'd0, bus.leds}, 32'd0);
      check("amid_rodada", {30'd0, bus.rodada}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      start_game(1'b0, oh);
      wait_state(4'd2, 4);
      watch_show(1, oh);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
